// File: rtl/ring_osc_freq_meter_pkg.sv
// Shared types and constants for the ring-oscillator frequency meter.
package ring_osc_freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2,
    DONE = 2'd3
  } state_e;

  // Settling cycles after start so the synchroniser pipeline is clean before gating.
  localparam int ARM_LEN = 2;

endpackage

// File: rtl/ring_osc_freq_meter_osc_sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector for one oscillator bit.
module osc_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic osc_i,
  output logic edge_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= osc_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign edge_o = sync_q & ~prev_q;

endmodule

// File: rtl/ring_osc_freq_meter.sv
// Gated edge counter: counts rising edges of one selected oscillator over a
// power-of-two window of clk cycles and reports a saturating result.
module ring_osc_freq_meter
  import ring_osc_freq_meter_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int CNT_W         = 16,
  parameter int MIN_GATE_LOG2 = 8,
  parameter int GATE_SEL_W    = 3,
  localparam int SEL_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CHANNELS-1:0]   osc_in,
  input  logic [SEL_W-1:0]      chan_sel,
  input  logic [GATE_SEL_W-1:0] gate_sel,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  input  logic [1:0]            byte_sel,
  output logic [7:0]            byte_out
);

  localparam int TMR_W = MIN_GATE_LOG2 + (1 << GATE_SEL_W);
  localparam logic [TMR_W-1:0] TMR_ONE = {{(TMR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CHANNELS-1:0] edge_vec;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_sync
    osc_sync_edge u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .osc_i  (osc_in[g]),
      .edge_o (edge_vec[g])
    );
  end

  state_e                state_q, state_d;
  logic [SEL_W-1:0]      chan_q, chan_d;
  logic [GATE_SEL_W-1:0] gsel_q, gsel_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic [CNT_W-1:0]      wcnt_q, wcnt_d;
  logic                  pend_q, pend_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;

  logic             sel_edge;
  logic [TMR_W-1:0] gate_len_m1;

  assign sel_edge    = edge_vec[chan_q];
  assign gate_len_m1 = (TMR_ONE << (MIN_GATE_LOG2 + int'(gsel_q))) - TMR_ONE;

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    gsel_d  = gsel_q;
    tmr_d   = tmr_q;
    wcnt_d  = wcnt_q;
    pend_d  = pend_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARM;
          chan_d  = (32'(chan_sel) >= CHANNELS) ? '0 : chan_sel;
          gsel_d  = gate_sel;
          wcnt_d  = '0;
          pend_d  = 1'b0;
          tmr_d   = TMR_W'(ARM_LEN - 1);
        end
      end
      ARM: begin
        if (tmr_q == '0) begin
          state_d = GATE;
          tmr_d   = gate_len_m1;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      GATE: begin
        if (sel_edge) begin
          if (&wcnt_q) pend_d = 1'b1;
          else         wcnt_d = wcnt_q + CNT_ONE;
        end
        if (tmr_q == '0) state_d = DONE;
        else             tmr_d   = tmr_q - TMR_ONE;
      end
      DONE: begin
        // Result registers and the done pulse update together on leaving DONE.
        count_d = wcnt_q;
        ovf_d   = pend_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      chan_q  <= '0;
      gsel_q  <= '0;
      tmr_q   <= '0;
      wcnt_q  <= '0;
      pend_q  <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      gsel_q  <= gsel_d;
      tmr_q   <= tmr_d;
      wcnt_q  <= wcnt_d;
      pend_q  <= pend_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  logic [31:0] cnt_ext;
  assign cnt_ext  = 32'(count_q);
  assign byte_out = cnt_ext[{byte_sel, 3'b000} +: 8];

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// Scoreboard bench: two meter instances (default and 8-bit/3-channel) driven by
// clk-synchronous square waves so every expected count is exact.
module tb_ring_osc_freq_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [3:0]  osc_a;
  logic [1:0]  chan_a, bsel_a;
  logic [2:0]  gsel_a;
  logic        start_a, busy_a, done_a, ovf_a;
  logic [15:0] count_a;
  logic [7:0]  bout_a;

  logic [2:0]  osc_b;
  logic [1:0]  chan_b, bsel_b;
  logic [2:0]  gsel_b;
  logic        start_b, busy_b, done_b, ovf_b;
  logic [7:0]  count_b;
  logic [7:0]  bout_b;

  ring_osc_freq_meter u_dut_a (
    .clk(clk), .rst_n(rst_n), .osc_in(osc_a), .chan_sel(chan_a), .gate_sel(gsel_a),
    .start(start_a), .busy(busy_a), .done(done_a), .count(count_a), .overflow(ovf_a),
    .byte_sel(bsel_a), .byte_out(bout_a)
  );

  ring_osc_freq_meter #(.CHANNELS(3), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .osc_in(osc_b), .chan_sel(chan_b), .gate_sel(gsel_b),
    .start(start_b), .busy(busy_b), .done(done_b), .count(count_b), .overflow(ovf_b),
    .byte_sel(bsel_b), .byte_out(bout_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Oscillator generator: ch0 period 4, ch1 period 8; A.ch2 held high; A.ch3 emits
  // exactly burst_req pulses of period 4 once requested.
  int t = 0;
  int burst_req = 0;
  int burst_done = 0;
  int bph = 0;
  always @(negedge clk) begin
    t = t + 1;
    osc_a[0] = (t % 4) < 2;
    osc_a[1] = (t % 8) < 4;
    osc_a[2] = 1'b1;
    if (burst_done < burst_req) begin
      osc_a[3] = (bph < 2);
      bph = bph + 1;
      if (bph == 4) begin
        bph = 0;
        burst_done = burst_done + 1;
      end
    end else begin
      osc_a[3] = 1'b0;
    end
    osc_b[0] = (t % 4) < 2;
    osc_b[1] = (t % 8) < 4;
    osc_b[2] = 1'b0;
  end

  typedef struct packed {
    logic [31:0] cnt;
    logic        ovf;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  task automatic push(input bit b, input logic [31:0] c, input logic o);
    exp_t e;
    e.cnt = c;
    e.ovf = o;
    if (b) qb.push_back(e);
    else   qa.push_back(e);
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (done_a === 1'b1) begin
      if (qa.size() == 0) chk("a_unexpected_done", 64'(done_a), 0);
      else begin
        e = qa.pop_front();
        chk("a_count", 64'(count_a), 64'(e.cnt));
        chk("a_ovf", 64'(ovf_a), 64'(e.ovf));
      end
    end
    if (done_b === 1'b1) begin
      if (qb.size() == 0) chk("b_unexpected_done", 64'(done_b), 0);
      else begin
        e = qb.pop_front();
        chk("b_count", 64'(count_b), 64'(e.cnt));
        chk("b_ovf", 64'(ovf_b), 64'(e.ovf));
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic start_run(input bit b, input logic [1:0] ch, input logic [2:0] gs);
    if (b) begin chan_b = ch; gsel_b = gs; start_b = 1'b1; end
    else   begin chan_a = ch; gsel_a = gs; start_a = 1'b1; end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    chk(b ? "b_busy_after_start" : "a_busy_after_start", 64'(b ? busy_b : busy_a), 1);
  endtask

  // Waits for done; cyc counts edges since the accepting edge. With chain set,
  // start is raised during DONE and held one more cycle for a back-to-back run.
  task automatic wait_done(input bit b, input int lat, input int from, input bit chain,
                           input logic [1:0] nch, input logic [2:0] ngs);
    int  cyc;
    bit  seen;
    cyc  = from;
    seen = 1'b0;
    while (!seen && cyc < lat + 20) begin
      if (chain && cyc == lat - 1) begin
        if (b) begin chan_b = nch; gsel_b = ngs; start_b = 1'b1; end
        else   begin chan_a = nch; gsel_a = ngs; start_a = 1'b1; end
      end
      @(negedge clk);
      cyc++;
      if ((b ? done_b : done_a) === 1'b1) seen = 1'b1;
    end
    chk(b ? "b_latency" : "a_latency", 64'(seen ? cyc : 0), 64'(lat));
    chk(b ? "b_busy_at_done" : "a_busy_at_done", 64'(b ? busy_b : busy_a), 0);
    if (chain) begin
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0; chan_a = '0; gsel_a = '0; bsel_a = '0;
    start_b = 1'b0; chan_b = '0; gsel_b = '0; bsel_b = '0;
    repeat (3) @(negedge clk);
    chk("a_rst_busy", 64'(busy_a), 0);
    chk("a_rst_done", 64'(done_a), 0);
    chk("a_rst_count", 64'(count_a), 0);
    chk("a_rst_ovf", 64'(ovf_a), 0);
    chk("b_rst_busy", 64'(busy_b), 0);
    chk("b_rst_done", 64'(done_b), 0);
    chk("b_rst_count", 64'(count_b), 0);
    chk("b_rst_ovf", 64'(ovf_b), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Channel 1, period 8, 256-cycle window.
    push(0, 32, 0);
    start_run(0, 2'd1, 3'd0);
    wait_done(0, 259, 0, 0, 2'd0, 3'd0);

    // Longer window: 512 / 8.
    push(0, 64, 0);
    start_run(0, 2'd1, 3'd1);
    wait_done(0, 515, 0, 0, 2'd0, 3'd0);

    // Re-start 10 cycles into GATE with new selects must be ignored.
    push(0, 32, 0);
    start_run(0, 2'd1, 3'd0);
    repeat (12) @(negedge clk);
    chan_a = 2'd0; gsel_a = 3'd1; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(0, 259, 13, 0, 2'd0, 3'd0);

    // Abort mid-GATE with a one-cycle reset; no done may follow.
    start_run(0, 2'd1, 3'd0);
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("a_abort_busy", 64'(busy_a), 0);
    chk("a_abort_count", 64'(count_a), 0);
    chk("a_abort_done", 64'(done_a), 0);
    // Channel 2 was high through reset: nothing to count.
    push(0, 0, 0);
    start_run(0, 2'd2, 3'd0);
    wait_done(0, 259, 0, 0, 2'd0, 3'd0);
    push(0, 32, 0);
    start_run(0, 2'd1, 3'd0);
    wait_done(0, 259, 0, 0, 2'd0, 3'd0);

    // Exactly 0x1234 pulses on channel 3 inside a 32768-cycle window.
    push(0, 32'h1234, 0);
    start_run(0, 2'd3, 3'd7);
    repeat (4) @(negedge clk);
    burst_req = 4660;
    wait_done(0, 32771, 4, 0, 2'd0, 3'd0);
    bsel_a = 2'd0; @(negedge clk); chk("a_byte0", 64'(bout_a), 64'h34);
    bsel_a = 2'd1; @(negedge clk); chk("a_byte1", 64'(bout_a), 64'h12);
    bsel_a = 2'd2; @(negedge clk); chk("a_byte2", 64'(bout_a), 64'h00);
    bsel_a = 2'd3; @(negedge clk); chk("a_byte3", 64'(bout_a), 64'h00);

    // 8-bit instance: 256 edges saturate; back-to-back restart in first IDLE cycle.
    push(1, 255, 1);
    push(1, 64, 0);
    start_run(1, 2'd0, 3'd2);
    wait_done(1, 1027, 0, 1, 2'd0, 3'd0);
    chk("b_chain_busy", 64'(busy_b), 1);
    chk("b_hold_count", 64'(count_b), 255);
    chk("b_hold_ovf", 64'(ovf_b), 1);
    wait_done(1, 259, 0, 0, 2'd0, 3'd0);

    // Out-of-range channel falls back to channel 0.
    push(1, 64, 0);
    start_run(1, 2'd3, 3'd0);
    wait_done(1, 259, 0, 0, 2'd0, 3'd0);
    bsel_b = 2'd0; @(negedge clk); chk("b_byte0", 64'(bout_b), 64'h40);
    bsel_b = 2'd1; @(negedge clk); chk("b_byte1", 64'(bout_b), 64'h00);

    repeat (5) @(negedge clk);
    chk("a_queue_empty", 64'(qa.size()), 0);
    chk("b_queue_empty", 64'(qb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
